// File: rtl/rr_request_queue.sv
// Four-channel request front-end for a round-robin arbiter: per-channel FIFOs
// drive REQ from occupancy, and the granted head is popped to one registered port.

module rr_rq_chan #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_req,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              nonempty,
    output logic [DATA_W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [AW:0]       cnt;
    logic              push;

    // Fullness comes from registered count only, so a pop never frees a slot in the same cycle.
    assign ready    = (cnt != (AW+1)'(DEPTH));
    assign nonempty = (cnt != '0);
    assign push     = push_req && ready;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: clearing the pointers discards all entries.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end
endmodule

module rr_request_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          IN_VALID,
    input  logic [4*DATA_W-1:0] IN_DATA,
    output logic [3:0]          IN_READY,
    input  logic [3:0]          GNT,
    output logic [3:0]          REQ,
    output logic                OUT_VALID,
    output logic [DATA_W-1:0]   OUT_DATA,
    output logic [1:0]          OUT_ID,
    output logic                GNT_ERR
);
    localparam int NUM_CH = 4;

    logic [NUM_CH-1:0]             ready, nonempty, pop;
    logic [NUM_CH-1:0][DATA_W-1:0] head;
    logic                          gnt_legal, pop_any;
    logic [DATA_W-1:0]             pop_data;
    logic [1:0]                    pop_id;

    // Zero or one-hot is legal; grants to empty channels simply fall through.
    assign gnt_legal = ((GNT & (GNT - 4'd1)) == 4'd0);
    assign pop       = GNT & nonempty & {NUM_CH{gnt_legal}};
    assign pop_any   = |pop;
    assign IN_READY  = ready;
    assign REQ       = nonempty;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
            rr_rq_chan #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_chan (
                .clk      (clk),
                .rst_n    (rst_n),
                .push_req (IN_VALID[i]),
                .pop      (pop[i]),
                .wdata    (IN_DATA[i*DATA_W +: DATA_W]),
                .ready    (ready[i]),
                .nonempty (nonempty[i]),
                .head     (head[i])
            );
        end
    endgenerate

    always_comb begin
        pop_data = '0;
        pop_id   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pop[i]) begin
                pop_data = head[i];
                pop_id   = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_ID    <= '0;
            GNT_ERR   <= 1'b0;
        end else begin
            OUT_VALID <= pop_any;
            if (pop_any) begin
                OUT_DATA <= pop_data;
                OUT_ID   <= pop_id;
            end
            if (!gnt_legal) GNT_ERR <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rr_request_queue.sv
// Bench for rr_request_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.

module tb_rr_request_queue;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      in_valid = '0;
    logic [4*DW-1:0] in_data = '0;
    logic [3:0]      gnt = '0;
    logic [3:0]      in_ready, req;
    logic            out_valid, gnt_err;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_id;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one queue per channel plus the expected output register.
    logic [DW-1:0] mq [4][$];
    logic          m_valid, m_err;
    logic [DW-1:0] m_data;
    logic [1:0]    m_id;

    always #5 clk = ~clk;

    rr_request_queue #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .IN_VALID  (in_valid),
        .IN_DATA   (in_data),
        .IN_READY  (in_ready),
        .GNT       (gnt),
        .REQ       (req),
        .OUT_VALID (out_valid),
        .OUT_DATA  (out_data),
        .OUT_ID    (out_id),
        .GNT_ERR   (gnt_err)
    );

    function automatic logic [3:0] exp_req();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (mq[i].size() != 0);
        return r;
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (mq[i].size() != DEPTH);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = '0;
        m_err   = 1'b0;
    endtask

    // Advance one clock with the inputs currently driven; the model follows the rules directly.
    task automatic step();
        int   sz [4];
        logic legal;
        legal = ($countones(gnt) <= 1);
        for (int i = 0; i < 4; i++) sz[i] = mq[i].size();
        m_valid = 1'b0;
        if (!legal) m_err = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (legal && gnt[i] && sz[i] > 0) begin
                m_data  = mq[i].pop_front();
                m_id    = 2'(i);
                m_valid = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++)
            if (in_valid[i] && sz[i] < DEPTH) mq[i].push_back(in_data[i*DW +: DW]);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = '0;
        gnt = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({out_valid, out_id, out_data, gnt_err} !== {1'b0, 2'd0, 8'h00, 1'b0})
            $display("FAIL reset_out: got v=%b id=%0d d=%h err=%b want all zero", out_valid, out_id, out_data, gnt_err);
        else n_pass++;
        n_checks++;
        if ({req, in_ready} !== {4'b0000, 4'b1111})
            $display("FAIL reset_req_ready: got req=%b ready=%b want 0000/1111", req, in_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [10:0] want [4];
        want[0] = {1'b1, 2'd0, 8'hA1};
        want[1] = {1'b1, 2'd0, 8'hA2};
        want[2] = {1'b0, 2'd0, 8'hA2};
        want[3] = {1'b0, 2'd0, 8'hA2};
        in_valid = 4'b0001; in_data[7:0] = 8'hA1; step();
        n_checks++;
        if (req !== 4'b0001) $display("FAIL basic_req_rise: got %b want 0001", req); else n_pass++;
        in_data[7:0] = 8'hA2; step();
        in_valid = '0; gnt = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if ({out_valid, out_id, out_data} !== want[k])
                $display("FAIL basic_out%0d: got %h want %h", k, {out_valid, out_id, out_data}, want[k]);
            else n_pass++;
        end
        gnt = '0;
        n_checks++;
        if ({req[0], gnt_err} !== 2'b00) $display("FAIL basic_after: got req0=%b err=%b want 0 0", req[0], gnt_err);
        else n_pass++;
    endtask

    task automatic test_fill();
        in_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            in_data[23:16] = DW'(8'h10 + k);
            step();
            if (k >= 3) begin
                n_checks++;
                if (in_ready[2] !== 1'b0) $display("FAIL fill_full%0d: got ready2=%b want 0", k, in_ready[2]);
                else n_pass++;
            end
        end
        in_valid = '0; gnt = 4'b0100;
        step();
        n_checks++;
        if ({out_valid, out_id, out_data, in_ready[2]} !== {1'b1, 2'd2, 8'h10, 1'b1})
            $display("FAIL fill_pop: got v=%b id=%0d d=%h ready2=%b want 1 2 10 1", out_valid, out_id, out_data, in_ready[2]);
        else n_pass++;
        for (int k = 1; k < 4; k++) begin
            step();
            n_checks++;
            if ({out_valid, out_id, out_data} !== {1'b1, 2'd2, DW'(8'h10 + k)})
                $display("FAIL fill_drain%0d: got v=%b id=%0d d=%h want 1 2 %h", k, out_valid, out_id, out_data, 8'h10 + k);
            else n_pass++;
        end
        step();
        gnt = '0;
        n_checks++;
        if ({out_valid, req[2]} !== 2'b00) $display("FAIL fill_no5th: got v=%b req2=%b want 0 0", out_valid, req[2]);
        else n_pass++;
    endtask

    task automatic test_push_pop_same();
        in_valid = 4'b0010;
        in_data[15:8] = 8'h30; step();
        in_data[15:8] = 8'h31; step();
        gnt = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            in_valid = (k < 3) ? 4'b0010 : 4'b0000;
            in_data[15:8] = DW'(8'h32 + k);
            step();
            n_checks++;
            if (k < 5) begin
                if ({out_valid, out_id, out_data} !== {1'b1, 2'd1, DW'(8'h30 + k)})
                    $display("FAIL pushpop_out%0d: got v=%b id=%0d d=%h want 1 1 %h", k, out_valid, out_id, out_data, 8'h30 + k);
                else n_pass++;
            end else begin
                if (out_valid !== 1'b0) $display("FAIL pushpop_end: got v=%b want 0", out_valid);
                else n_pass++;
            end
            if (k == 2) begin
                n_checks++;
                if ({req[1], in_ready[1]} !== 2'b11) $display("FAIL pushpop_occ: got req1=%b ready1=%b want 1 1", req[1], in_ready[1]);
                else n_pass++;
            end
        end
        gnt = '0;
    endtask

    task automatic test_illegal_grant();
        in_valid = 4'b0110; in_data[15:8] = 8'h41; in_data[23:16] = 8'h42; step();
        in_valid = '0; gnt = 4'b0110; step();
        n_checks++;
        if ({out_valid, gnt_err, req} !== {1'b0, 1'b1, 4'b0110})
            $display("FAIL illegal_gnt: got v=%b err=%b req=%b want 0 1 0110", out_valid, gnt_err, req);
        else n_pass++;
        gnt = 4'b0010; step();
        n_checks++;
        if ({out_valid, out_id, out_data, gnt_err} !== {1'b1, 2'd1, 8'h41, 1'b1})
            $display("FAIL illegal_after1: got v=%b id=%0d d=%h err=%b want 1 1 41 1", out_valid, out_id, out_data, gnt_err);
        else n_pass++;
        gnt = 4'b0100; step();
        n_checks++;
        if ({out_valid, out_id, out_data, gnt_err} !== {1'b1, 2'd2, 8'h42, 1'b1})
            $display("FAIL illegal_after2: got v=%b id=%0d d=%h err=%b want 1 2 42 1", out_valid, out_id, out_data, gnt_err);
        else n_pass++;
        gnt = '0;
    endtask

    task automatic test_round_robin();
        int         ptr;
        int         ids [$];
        logic [3:0] m0, m1;
        apply_reset();
        in_valid = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) in_data[c*DW +: DW] = DW'(8'h50 + c * 2 + k);
            step();
        end
        in_valid = '0;
        ptr = 3;
        for (int cyc = 0; cyc < 16; cyc++) begin
            gnt = '0;
            for (int j = 1; j <= 4; j++) begin
                if (gnt == 4'b0000 && req[(ptr + j) % 4]) begin
                    gnt[(ptr + j) % 4] = 1'b1;
                    ptr = (ptr + j) % 4;
                end
            end
            step();
            n_checks++;
            if ({out_valid, out_id, out_data} !== {m_valid, m_id, m_data})
                $display("FAIL rr_out%0d: got %h want %h", cyc, {out_valid, out_id, out_data}, {m_valid, m_id, m_data});
            else n_pass++;
            if (out_valid) ids.push_back(int'(out_id));
        end
        gnt = '0;
        m0 = '0; m1 = '0;
        for (int k = 0; k < ids.size() && k < 8; k++) begin
            if (k < 4) m0[ids[k]] = 1'b1; else m1[ids[k]] = 1'b1;
        end
        n_checks++;
        if ({ids.size(), m0, m1} !== {32'd8, 4'hF, 4'hF})
            $display("FAIL rr_fair: got pops=%0d round0=%b round1=%b want 8 1111 1111", ids.size(), m0, m1);
        else n_pass++;
    endtask

    task automatic test_random();
        int r;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid = 4'($urandom);
            in_data  = {$urandom};
            r = $urandom_range(0, 99);
            if (r < 3) begin
                gnt = 4'($urandom);
                if ($countones(gnt) < 2) gnt = 4'b1001;
            end else if (r < 25) gnt = '0;
            else gnt = 4'b0001 << $urandom_range(0, 3);
            step();
            n_checks++;
            if ({out_valid, out_id, out_data, req, in_ready, gnt_err} !==
                {m_valid, m_id, m_data, exp_req(), exp_ready(), m_err})
                $display("FAIL random%0d: got v=%b id=%0d d=%h req=%b rdy=%b err=%b want v=%b id=%0d d=%h req=%b rdy=%b err=%b",
                         cyc, out_valid, out_id, out_data, req, in_ready, gnt_err,
                         m_valid, m_id, m_data, exp_req(), exp_ready(), m_err);
            else n_pass++;
        end
        in_valid = '0; gnt = '0;
    endtask

    task automatic test_async_reset();
        in_valid = 4'b1001; in_data[7:0] = 8'h61; in_data[31:24] = 8'h63; step();
        in_valid = 4'b0001; in_data[7:0] = 8'h62; step();
        in_valid = '0; gnt = 4'b0001; step();
        gnt = '0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_id, out_data, req, in_ready, gnt_err} !== {1'b0, 2'd0, 8'h00, 4'b0000, 4'b1111, 1'b0})
            $display("FAIL async_reset: got v=%b id=%0d d=%h req=%b rdy=%b err=%b want 0 0 00 0000 1111 0",
                     out_valid, out_id, out_data, req, in_ready, gnt_err);
        else n_pass++;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            gnt = (k < 3) ? 4'b0001 : 4'b1000;
            step();
            n_checks++;
            if ({out_valid, req} !== {1'b0, 4'b0000})
                $display("FAIL async_stale%0d: got v=%b req=%b want 0 0000", k, out_valid, req);
            else n_pass++;
        end
        gnt = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        #3;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
        test_fill();
        test_push_pop_same();
        test_illegal_grant();
        test_round_robin();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
